// File: rtl/idct_transpose_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idct_transpose_buffer
// Brief    : Ping-pong 8x8 transpose buffer between IDCT row and column passes.
// Revision : 1.0 - initial release
// ============================================================================
module idct_transpose_buffer #(
    parameter int WIDTH = 12
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             row_valid_in,
    output logic             row_ready_out,
    input  logic [WIDTH-1:0] row_in_0,
    input  logic [WIDTH-1:0] row_in_1,
    input  logic [WIDTH-1:0] row_in_2,
    input  logic [WIDTH-1:0] row_in_3,
    input  logic [WIDTH-1:0] row_in_4,
    input  logic [WIDTH-1:0] row_in_5,
    input  logic [WIDTH-1:0] row_in_6,
    input  logic [WIDTH-1:0] row_in_7,
    output logic             col_valid_out,
    input  logic             col_ready_in,
    output logic [WIDTH-1:0] col_out_0,
    output logic [WIDTH-1:0] col_out_1,
    output logic [WIDTH-1:0] col_out_2,
    output logic [WIDTH-1:0] col_out_3,
    output logic [WIDTH-1:0] col_out_4,
    output logic [WIDTH-1:0] col_out_5,
    output logic [WIDTH-1:0] col_out_6,
    output logic [WIDTH-1:0] col_out_7,
    output logic [2:0]       col_idx_out,
    output logic             col_last_out
);

    localparam logic [2:0] C_LAST_IDX = 3'd7;

    logic [WIDTH-1:0] r_bank [2][8][8];
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [2:0]       r_wr_row;
    logic [2:0]       r_rd_col;
    logic [1:0]       r_bank_full;

    logic [1:0]       w_bank_full_nxt;
    logic [WIDTH-1:0] w_row [8];
    logic [WIDTH-1:0] w_col [8];
    logic             w_row_acc;
    logic             w_col_acc;
    logic             w_row_done;
    logic             w_col_done;

    assign w_row[0] = row_in_0;
    assign w_row[1] = row_in_1;
    assign w_row[2] = row_in_2;
    assign w_row[3] = row_in_3;
    assign w_row[4] = row_in_4;
    assign w_row[5] = row_in_5;
    assign w_row[6] = row_in_6;
    assign w_row[7] = row_in_7;

    // Handshake status depends only on registers, never on the partner's valid/ready.
    assign row_ready_out = !r_bank_full[r_wr_bank];
    assign col_valid_out = r_bank_full[r_rd_bank];
    assign col_idx_out   = r_rd_col;
    assign col_last_out  = col_valid_out && (r_rd_col == C_LAST_IDX);

    assign w_row_acc  = row_valid_in && row_ready_out;
    assign w_col_acc  = col_valid_out && col_ready_in;
    assign w_row_done = w_row_acc && (r_wr_row == C_LAST_IDX);
    assign w_col_done = w_col_acc && (r_rd_col == C_LAST_IDX);

    generate
        for (genvar r = 0; r < 8; r++) begin : g_col_lane
            assign w_col[r] = r_bank[r_rd_bank][r][r_rd_col];
        end
    endgenerate

    assign col_out_0 = w_col[0];
    assign col_out_1 = w_col[1];
    assign col_out_2 = w_col[2];
    assign col_out_3 = w_col[3];
    assign col_out_4 = w_col[4];
    assign col_out_5 = w_col[5];
    assign col_out_6 = w_col[6];
    assign col_out_7 = w_col[7];

    // Set and clear never hit the same bank: writes need it empty, reads need it full.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_row_done) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_col_done) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_row    <= 3'd0;
            r_rd_col    <= 3'd0;
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_row_acc) begin
                if (w_row_done) begin
                    r_wr_bank <= !r_wr_bank;
                    r_wr_row  <= 3'd0;
                end else begin
                    r_wr_row  <= r_wr_row + 3'd1;
                end
            end
            if (w_col_acc) begin
                if (w_col_done) begin
                    r_rd_bank <= !r_rd_bank;
                    r_rd_col  <= 3'd0;
                end else begin
                    r_rd_col  <= r_rd_col + 3'd1;
                end
            end
        end
    end

    // Sample storage is cleared on reset so no pre-reset data can resurface.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        r_bank[b][r][c] <= '0;
                    end
                end
            end
        end else if (w_row_acc) begin
            for (int c = 0; c < 8; c++) begin
                r_bank[r_wr_bank][r_wr_row][c] <= w_row[c];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idct_transpose_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_idct_transpose_buffer
// Brief    : Scoreboard bench for idct_transpose_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idct_transpose_buffer;

    localparam int W = 12;

    typedef struct {
        logic [7:0][W-1:0] lanes;
        logic [2:0]        idx;
    } col_t;

    typedef struct {
        logic       rv;
        logic       cr;
        logic       exp_rr;
        logic       exp_cv;
        logic [2:0] exp_idx;
    } vec_t;

    logic              clk_in       = 1'b0;
    logic              rst_in       = 1'b0;
    logic              row_valid_in = 1'b0;
    logic              col_ready_in = 1'b0;
    logic              row_ready_out;
    logic              col_valid_out;
    logic              col_last_out;
    logic [2:0]        col_idx_out;
    logic [7:0][W-1:0] row_d = '0;
    wire  [7:0][W-1:0] col_d;

    int   n_checks    = 0;
    int   n_errors    = 0;
    int   col_acc_cnt = 0;
    int   mdl_row     = 0;
    logic [W-1:0] mdl [8][8];
    col_t sb [$];

    idct_transpose_buffer #(.WIDTH(W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .row_valid_in  (row_valid_in),
        .row_ready_out (row_ready_out),
        .row_in_0      (row_d[0]),
        .row_in_1      (row_d[1]),
        .row_in_2      (row_d[2]),
        .row_in_3      (row_d[3]),
        .row_in_4      (row_d[4]),
        .row_in_5      (row_d[5]),
        .row_in_6      (row_d[6]),
        .row_in_7      (row_d[7]),
        .col_valid_out (col_valid_out),
        .col_ready_in  (col_ready_in),
        .col_out_0     (col_d[0]),
        .col_out_1     (col_d[1]),
        .col_out_2     (col_d[2]),
        .col_out_3     (col_d[3]),
        .col_out_4     (col_d[4]),
        .col_out_5     (col_d[5]),
        .col_out_6     (col_d[6]),
        .col_out_7     (col_d[7]),
        .col_idx_out   (col_idx_out),
        .col_last_out  (col_last_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_row(input logic [7:0][W-1:0] d);
        int   k;
        logic acc;
        k   = 0;
        acc = 1'b0;
        row_d        = d;
        row_valid_in = 1'b1;
        do begin
            acc = row_ready_out;
            tick();
            k++;
        end while (!acc && k < 1000);
        row_valid_in = 1'b0;
        chk("send_row_accept", acc, 1'b1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        col_ready_in = 1'b1;
        while ((sb.size() != 0 || col_valid_out) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_in_time", (k < 200), 1'b1);
    endtask

    // Reference model: handshakes are observed mid-cycle, where inputs and outputs are settled.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            sb.delete();
            mdl_row = 0;
        end else begin
            if (row_valid_in && row_ready_out) begin
                for (int c = 0; c < 8; c++) mdl[mdl_row][c] = row_d[c];
                if (mdl_row == 7) begin
                    for (int c = 0; c < 8; c++) begin
                        col_t e;
                        for (int r = 0; r < 8; r++) e.lanes[r] = mdl[r][c];
                        e.idx = 3'(c);
                        sb.push_back(e);
                    end
                    mdl_row = 0;
                end else begin
                    mdl_row++;
                end
            end
            if (col_valid_out && col_ready_in) begin
                col_acc_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_column", col_valid_out, 1'b0);
                end else begin
                    col_t e;
                    e = sb.pop_front();
                    chk("col_data", col_d, e.lanes);
                    chk("col_idx", col_idx_out, e.idx);
                    chk("col_last", col_last_out, (e.idx == 3'd7));
                end
            end
        end
    end

    initial begin
        vec_t              tbl [29];
        logic [7:0][W-1:0] d;
        logic [W-1:0]      pick [3];
        int                cnt0;
        logic              rows_done;

        pick[0] = 12'h800;
        pick[1] = 12'h7FF;
        pick[2] = 12'hFFF;

        // Backpressure schedule: fill both banks, stall, then drain one bank.
        for (int i = 0; i < 29; i++) begin
            tbl[i].rv      = 1'b1;
            tbl[i].cr      = (i >= 19 && i <= 26);
            tbl[i].exp_rr  = (i < 16 || i >= 27);
            tbl[i].exp_cv  = (i >= 8);
            tbl[i].exp_idx = (i >= 19 && i <= 26) ? 3'(i - 19) : 3'd0;
        end
        tbl[28].rv = 1'b0;

        // Reset state
        #1;
        chk("rst_row_ready", row_ready_out, 1'b1);
        chk("rst_col_valid", col_valid_out, 1'b0);
        chk("rst_col_idx", col_idx_out, 3'd0);
        chk("rst_col_last", col_last_out, 1'b0);
        chk("rst_col_data", col_d, '0);
        tick();
        tick();
        rst_in = 1'b1;

        // Single block, latency and ordering
        col_ready_in = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'(r * 16 + c);
            send_row(d);
        end
        chk("lat_col_valid", col_valid_out, 1'b1);
        chk("lat_col_idx", col_idx_out, 3'd0);
        wait_drain();

        // Three back-to-back blocks, both sides always ready
        cnt0 = col_acc_cnt;
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < 8; c++) d[c] = W'($urandom);
            chk("b2b_row_ready", row_ready_out, 1'b1);
            send_row(d);
        end
        repeat (8) tick();
        chk("b2b_contiguous_cols", col_acc_cnt - cnt0, 24);
        wait_drain();

        // Table-driven backpressure
        for (int i = 0; i < 29; i++) begin
            for (int c = 0; c < 8; c++) row_d[c] = W'($urandom);
            row_valid_in = tbl[i].rv;
            col_ready_in = tbl[i].cr;
            chk("bp_row_ready", row_ready_out, tbl[i].exp_rr);
            chk("bp_col_valid", col_valid_out, tbl[i].exp_cv);
            chk("bp_col_idx", col_idx_out, tbl[i].exp_idx);
            if (tbl[i].exp_cv && sb.size() > 0) chk("bp_hold_data", col_d, sb[0].lanes);
            tick();
        end
        row_valid_in = 1'b0;
        col_ready_in = 1'b1;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'($urandom);
            send_row(d);
        end
        wait_drain();

        // Signed extremes pass through bit-exact
        col_ready_in = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = pick[(r + c) % 3];
            send_row(d);
        end
        for (int r = 0; r < 8; r++) d[r] = pick[r % 3];
        chk("signed_col0", col_d, d);
        wait_drain();

        // Random throttling on both sides
        rows_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 50; b++) begin
                    for (int r = 0; r < 8; r++) begin
                        while ($urandom_range(0, 2) == 0) tick();
                        for (int c = 0; c < 8; c++) d[c] = W'($urandom);
                        send_row(d);
                    end
                end
                rows_done = 1'b1;
            end
            begin
                while (!rows_done) begin
                    col_ready_in = ($urandom_range(0, 1) == 1);
                    tick();
                end
            end
        join
        wait_drain();

        // Reset after five rows of a block
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'($urandom);
            send_row(d);
        end
        rst_in = 1'b0;
        #1;
        chk("rst1_col_valid", col_valid_out, 1'b0);
        chk("rst1_row_ready", row_ready_out, 1'b1);
        tick();
        rst_in = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'(12'h100 + r * 8 + c);
            send_row(d);
        end
        chk("rst1_fresh_valid", col_valid_out, 1'b1);
        chk("rst1_fresh_idx", col_idx_out, 3'd0);
        wait_drain();

        // Reset while draining at column 3
        col_ready_in = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'($urandom);
            send_row(d);
        end
        col_ready_in = 1'b1;
        repeat (3) tick();
        col_ready_in = 1'b0;
        chk("rst2_pre_idx", col_idx_out, 3'd3);
        rst_in = 1'b0;
        #1;
        chk("rst2_col_valid", col_valid_out, 1'b0);
        chk("rst2_row_ready", row_ready_out, 1'b1);
        chk("rst2_col_idx", col_idx_out, 3'd0);
        chk("rst2_col_data", col_d, '0);
        tick();
        rst_in = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = W'(12'h600 - r * 8 - c);
            send_row(d);
        end
        wait_drain();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idct_transpose_buffer.md
Name: idct_transpose_buffer

Overview:
- Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D IDCT stages of the 2-D IDCT.
- Accepts one 8-sample row per handshake, which is the row-pass output.
- Emits one 8-sample column per handshake, which is the column-pass input.
- Two banks allow one block to fill while the previous block drains, sustaining one row in and one column out per cycle.

Parameters:
WIDTH, 12, bit width of each sample; data passes through unmodified (two's complement, no arithmetic).

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_in  input  1  asynchronous, active-low reset.
row_valid_in  input  1  row_in_0..7 holds a valid row.
row_ready_out  output  1  buffer can accept a row this cycle.
row_in_0 .. row_in_7  input  WIDTH each  row samples; lane k is column k of the current row.
col_valid_out  output  1  col_out_0..7 holds a valid column.
col_ready_in  input  1  downstream accepts a column this cycle.
col_out_0 .. col_out_7  output  WIDTH each  column samples; lane r is row r of the current column.
col_idx_out  output  3  index (0..7) of the column currently presented.
col_last_out  output  1  high when col_idx_out==7 and col_valid_out==1.

Behaviour:
- Storage: two banks, each 8x8 registers of WIDTH bits.
- Control registers: wr_bank (1b), rd_bank (1b), wr_row (3b), rd_col (3b), bank_full[1:0].
- Reset (rst_in low, asynchronous), effective immediately:
  - wr_bank=0, rd_bank=0, wr_row=0, rd_col=0, bank_full=2'b00.
  - All bank registers cleared to 0.
  - Outputs: row_ready_out=1, col_valid_out=0, col_idx_out=0, col_last_out=0, col_out_*=0.
  - Reset mid-operation discards partial and full blocks; no stale column is ever emitted after reset.
- row_ready_out = !bank_full[wr_bank]. Combinational from registers only, with no dependency on row_valid_in.
- Row accept (row_valid_in && row_ready_out):
  - bank[wr_bank][wr_row][k] <= row_in_k.
  - If wr_row==7: bank_full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0.
  - Otherwise wr_row increments.
- Column presentation:
  - col_valid_out = bank_full[rd_bank].
  - col_out_r = bank[rd_bank][r][rd_col].
  - col_idx_out = rd_col.
  - These are combinational reads of registers; there is no output pipeline register.
- Column accept (col_valid_out && col_ready_in):
  - If rd_col==7: bank_full[rd_bank] <= 0, rd_bank toggles, rd_col <= 0.
  - Otherwise rd_col increments.
- Latency: the 8th row accepted at edge N gives col_valid_out=1, col_idx_out=0 in the cycle after edge N. This holds when the other bank is not still draining.
- Throughput: 1 row/cycle in and 1 column/cycle out sustained; no bubble between blocks when both sides are always ready.
- Hold rule: while col_valid_out && !col_ready_in, col_out_*, col_idx_out and col_valid_out stay stable. A full bank is never written.
- Simultaneous set/clear in one cycle:
  - Set of bank_full[wr_bank] and clear of bank_full[rd_bank] both take effect.
  - They never target the same bank: a write requires that bank empty, a read requires it full.
- Both banks full: row_ready_out=0. It returns to 1 in the cycle after the last column (idx 7) of rd_bank is accepted.
- Both banks empty: col_valid_out=0. col_ready_in is ignored.
- Gaps on either side (valid or ready low) freeze the corresponding counter. There is no timeout.
- Counters wrap 7->0 only through the block-complete path above.

Test Plan:
- Single block, sample (r,c) = r*16+c, col_ready_in=1: column c lane r equals r*16+c. col_idx_out runs 0..7 with col_last_out on idx 7. The first column appears the cycle after row 7 is accepted.
- Three back-to-back blocks, row_valid_in and col_ready_in held high: 24 rows accepted in 24 consecutive cycles with row_ready_out never low. 24 columns emitted contiguously, with blocks in order and correctly transposed.
- Backpressure, col_ready_in=0: row_ready_out falls after 16 rows accepted, and row 17 is held off. Then raise col_ready_in for 1 cycle followed by 7 more cycles: row_ready_out rises the cycle after the idx-7 accept. Outputs stay stable while stalled.
- Signed pass-through, WIDTH=12: lanes carry 12'h800, 12'h7FF and 12'hFFF, and they appear bit-exact at the outputs.
- Random valid/ready throttling over 50 blocks: the output stream matches a software transpose model with no dropped or duplicated columns.
- Reset asserted after 5 rows of block 0, and again during draining at idx 3:
  - During reset: col_valid_out=0, row_ready_out=1.
  - After release, a fresh block transposes correctly, with no residue from pre-reset data.
